// File: rtl/vga_frame_scanout.sv
// vga_frame_scanout: VGA timing generator and framebuffer reader.
// Scans the framebuffer in raster order, centres the latched image inside
// the visible area with a black border and drives 8-bit grayscale on R/G/B.
// All timing flags ride a delay line so they reach the output registers
// together with the framebuffer data for the same pixel.
module vga_frame_scanout #(
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        img_width,
    input  logic [9:0]        img_height,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_data,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_blank_n,
    output logic              frame_start
);
    // Counter / geometry width; wide enough for every supported timing.
    localparam int CW    = 12;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_VIS_C  = CW'(H_VIS);
    localparam logic [CW-1:0] H_LAST_C = CW'(H_TOT - 1);
    localparam logic [CW-1:0] HS_BEG_C = CW'(H_VIS + H_FP);
    localparam logic [CW-1:0] HS_END_C = CW'(H_VIS + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_VIS_C  = CW'(V_VIS);
    localparam logic [CW-1:0] V_LAST_C = CW'(V_TOT - 1);
    localparam logic [CW-1:0] VS_BEG_C = CW'(V_VIS + V_FP);
    localparam logic [CW-1:0] VS_END_C = CW'(V_VIS + V_FP + V_SYNC);

    // Delay-line field positions (all active-high inside the pipe).
    localparam int PW    = 5;
    localparam int P_HS  = 0;
    localparam int P_VS  = 1;
    localparam int P_VIS = 2;
    localparam int P_IMG = 3;
    localparam int P_FS  = 4;

    logic [CW-1:0]     h_cnt_reg, v_cnt_reg;
    logic [CW-1:0]     w_reg, h_reg;
    logic [ADDR_W-1:0] addr_cnt_reg;
    logic [PW-1:0]     pipe_reg [0:MEM_LATENCY];

    logic              origin;
    logic [CW-1:0]     w_clamp, h_clamp, w_eff, h_eff, x_off, y_off;
    logic              hs_raw, vs_raw, vis_raw, in_img;
    logic [ADDR_W-1:0] addr_base;
    logic [PW-1:0]     stage0;
    logic [PW-1:0]     tap;

    // Stage-0 decode: raw timing, clamped geometry and the image window.
    // On the frame origin the freshly clamped size is used directly so the
    // window matches the geometry being latched on that same edge.
    always_comb begin
        origin  = (h_cnt_reg == '0) && (v_cnt_reg == '0);
        w_clamp = ({2'b00, img_width}  > H_VIS_C) ? H_VIS_C : {2'b00, img_width};
        h_clamp = ({2'b00, img_height} > V_VIS_C) ? V_VIS_C : {2'b00, img_height};
        w_eff   = origin ? w_clamp : w_reg;
        h_eff   = origin ? h_clamp : h_reg;
        x_off   = (H_VIS_C - w_eff) >> 1;
        y_off   = (V_VIS_C - h_eff) >> 1;
        hs_raw  = (h_cnt_reg >= HS_BEG_C) && (h_cnt_reg < HS_END_C);
        vs_raw  = (v_cnt_reg >= VS_BEG_C) && (v_cnt_reg < VS_END_C);
        vis_raw = (h_cnt_reg < H_VIS_C) && (v_cnt_reg < V_VIS_C);
        in_img  = vis_raw
                  && (h_cnt_reg >= x_off) && (h_cnt_reg < x_off + w_eff)
                  && (v_cnt_reg >= y_off) && (v_cnt_reg < y_off + h_eff);
        addr_base = origin ? '0 : addr_cnt_reg;
        stage0  = '0;
        stage0[P_HS]  = hs_raw;
        stage0[P_VS]  = vs_raw;
        stage0[P_VIS] = vis_raw;
        stage0[P_IMG] = in_img;
        stage0[P_FS]  = origin;
        tap     = pipe_reg[MEM_LATENCY];
    end

    // Horizontal / vertical raster counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_cnt_reg == H_LAST_C) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == V_LAST_C) ? '0 : v_cnt_reg + CW'(1);
        end else begin
            h_cnt_reg <= h_cnt_reg + CW'(1);
        end
    end

    // Geometry is sampled once per frame so mid-frame input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_reg <= '0;
            h_reg <= '0;
        end else if (origin) begin
            w_reg <= w_clamp;
            h_reg <= h_clamp;
        end
    end

    // Incremental raster address: one step per image pixel, so the count
    // tops out at W*H and the last presented address is W*H-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_cnt_reg <= '0;
            fb_addr      <= '0;
        end else if (in_img) begin
            fb_addr      <= addr_base;
            addr_cnt_reg <= addr_base + ADDR_W'(1);
        end else if (origin) begin
            addr_cnt_reg <= '0;
        end
    end

    // Delay line: MEM_LATENCY+1 stages to line the flags up with fb_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= MEM_LATENCY; i++) begin
                pipe_reg[i] <= '0;
            end
        end else begin
            pipe_reg[0] <= stage0;
            for (int i = 1; i <= MEM_LATENCY; i++) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
        end
    end

    // Output registers: syncs active-low, pixel black outside the image.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vga_blank_n <= 1'b0;
            frame_start <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            vga_hsync   <= ~tap[P_HS];
            vga_vsync   <= ~tap[P_VS];
            vga_blank_n <= tap[P_VIS];
            frame_start <= tap[P_FS];
            vga_r       <= tap[P_IMG] ? fb_data : 8'd0;
            vga_g       <= tap[P_IMG] ? fb_data : 8'd0;
            vga_b       <= tap[P_IMG] ? fb_data : 8'd0;
        end
    end

endmodule

// File: tb/tb_vga_frame_scanout.sv
// tb_vga_frame_scanout: bench for vga_frame_scanout using a reduced raster
// (64x48 visible, 80x55 total) so that a dozen frames stay short. A model
// framebuffer returns the low address byte; a position-based reference
// model predicts every output cycle; a table of geometries checks window
// placement, final address and sync counts per frame.
`timescale 1ns/1ps
module tb_vga_frame_scanout;
    localparam int H_VIS = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_VIS = 48, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int ML = 2, ADDR_W = 19;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int LAT = ML + 2;
    localparam int MAXF = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [9:0] img_width = 10'd16, img_height = 10'd12;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0] fb_data, vga_r, vga_g, vga_b;
    logic vga_hsync, vga_vsync, vga_blank_n, frame_start;

    vga_frame_scanout #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .MEM_LATENCY(ML), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset),
        .img_width(img_width), .img_height(img_height),
        .fb_addr(fb_addr), .fb_data(fb_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_blank_n(vga_blank_n), .frame_start(frame_start)
    );

    always #20 clk = ~clk;

    // Model framebuffer: word = low byte of its address, ML cycles of latency.
    logic [7:0] ram_pipe [0:ML-1] = '{default: 8'd0};
    always @(posedge clk) begin
        ram_pipe[0] <= fb_addr[7:0];
        for (int i = 1; i < ML; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign fb_data = ram_pipe[ML-1];

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    int k = -1;
    int gw [MAXF];
    int gh [MAXF];
    int st_first_col [MAXF];
    int st_first_line [MAXF];
    int st_nz [MAXF];
    int st_hs [MAXF];
    int st_vs [MAXF];
    int st_bn [MAXF];
    int st_last_addr [MAXF];
    int exp_addr = 0;
    int ln_bad = 0, ln_col = 0;
    logic [27:0] ln_act, ln_exp;
    int ad_bad = 0, ad_col = 0, ad_act = 0, ad_exp = 0;

    function automatic int clampv(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic bit in_image(input int f, input int line, input int col);
        int xo, yo;
        xo = (H_VIS - gw[f]) / 2;
        yo = (V_VIS - gh[f]) / 2;
        return col < H_VIS && line < V_VIS && col >= xo && col < xo + gw[f]
               && line >= yo && line < yo + gh[f];
    endfunction

    function automatic int pix_index(input int f, input int line, input int col);
        int xo, yo;
        xo = (H_VIS - gw[f]) / 2;
        yo = (V_VIS - gh[f]) / 2;
        return (line - yo) * gw[f] + (col - xo);
    endfunction

    // Cycle-by-cycle reference: output at cycle k shows raster position k-LAT;
    // fb_addr at cycle k reflects position k-1. Mismatches are folded per line.
    always @(negedge clk) begin : mon
        int p, f, r, line, col, q, fq, c, ln;
        logic [7:0] e_rgb;
        logic e_hs, e_vs, e_bn, e_fs;
        logic [27:0] act, expv;
        if (reset) begin
            k = -1; exp_addr = 0; ln_bad = 0; ad_bad = 0;
        end else begin
            k = k + 1;
            if (k % FRAME == 0 && k / FRAME < MAXF) begin
                f = k / FRAME;
                gw[f] = clampv(int'(img_width), H_VIS);
                gh[f] = clampv(int'(img_height), V_VIS);
                st_first_col[f] = -1; st_first_line[f] = -1;
                st_nz[f] = 0; st_hs[f] = 0; st_vs[f] = 0; st_bn[f] = 0;
                st_last_addr[f] = -1;
            end
            act = {vga_hsync, vga_vsync, vga_blank_n, frame_start, vga_r, vga_g, vga_b};
            col = -1; line = 0; f = 0;
            if (k < LAT) begin
                expv = {4'b1100, 24'h0};
            end else begin
                p = k - LAT; f = p / FRAME; r = p % FRAME;
                line = r / H_TOT; col = r % H_TOT;
                e_hs = !(col >= H_VIS + H_FP && col < H_VIS + H_FP + H_SYNC);
                e_vs = !(line >= V_VIS + V_FP && line < V_VIS + V_FP + V_SYNC);
                e_bn = col < H_VIS && line < V_VIS;
                e_fs = (r == 0);
                e_rgb = in_image(f, line, col) ? 8'(pix_index(f, line, col) & 255) : 8'd0;
                expv = {e_hs, e_vs, e_bn, e_fs, e_rgb, e_rgb, e_rgb};
                if (vga_r == 8'd1 && st_first_col[f] < 0) begin
                    st_first_col[f] = col; st_first_line[f] = line;
                end
                if (vga_r != 8'd0) st_nz[f]++;
                if (!vga_hsync) st_hs[f]++;
                if (!vga_vsync) st_vs[f]++;
                if (vga_blank_n) st_bn[f]++;
            end
            if (act !== expv) begin
                if (ln_bad == 0) begin ln_col = col; ln_act = act; ln_exp = expv; end
                ln_bad++;
            end
            if (col == H_TOT - 1) begin
                n_checks++;
                if (ln_bad != 0) begin
                    n_fail++;
                    $display("FAIL pixel_line frame %0d line %0d: %0d bad cycles, first col %0d got %h expected %h",
                             f, line, ln_bad, ln_col, ln_act, ln_exp);
                end
                ln_bad = 0;
            end
            if (k >= 1) begin
                q = k - 1; fq = q / FRAME; r = q % FRAME;
                ln = r / H_TOT; c = r % H_TOT;
                if (in_image(fq, ln, c)) exp_addr = pix_index(fq, ln, c);
                if (int'(fb_addr) != exp_addr) begin
                    if (ad_bad == 0) begin ad_col = c; ad_act = int'(fb_addr); ad_exp = exp_addr; end
                    ad_bad++;
                end
                if (r == FRAME - 1) st_last_addr[fq] = int'(fb_addr);
                if (c == H_TOT - 1) begin
                    n_checks++;
                    if (ad_bad != 0) begin
                        n_fail++;
                        $display("FAIL fb_addr_line frame %0d line %0d: %0d bad cycles, first col %0d got %0d expected %0d",
                                 fq, ln, ad_bad, ad_col, ad_act, ad_exp);
                    end
                    ad_bad = 0;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic wait_k(input int target);
        int guard = 0;
        while (k < target && guard < 100000) begin
            @(posedge clk);
            guard++;
        end
        if (k < target) begin
            $display("FAIL wait_k: got k=%0d expected %0d", k, target);
            n_fail++;
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $fatal(1);
        end
        #2;
    endtask

    typedef struct {
        int win; int hin; int last; int first_col; int first_line; int nz;
    } vec_t;
    vec_t tbl [6];

    task automatic check_frame(input int f, input int last, input int fc, input int fl, input int nz);
        check($sformatf("last_addr f%0d", f), st_last_addr[f], last);
        check($sformatf("first_col f%0d", f), st_first_col[f], fc);
        check($sformatf("first_line f%0d", f), st_first_line[f], fl);
        check($sformatf("nonzero f%0d", f), st_nz[f], nz);
        check($sformatf("hsync_low f%0d", f), st_hs[f], H_SYNC * V_TOT);
        check($sformatf("vsync_low f%0d", f), st_vs[f], V_SYNC * H_TOT);
        check($sformatf("blank_high f%0d", f), st_bn[f], H_VIS * V_VIS);
        $display("frame %0d: geometry %0dx%0d last_addr %0d first pixel (%0d,%0d)",
                 f, gw[f], gh[f], st_last_addr[f], st_first_col[f], st_first_line[f]);
    endtask

    initial begin : watchdog
        #(40 * 70000);
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin : drive
        int pos;
        bit found;
        // {width in, height in, last addr, col/line of pixel value 1, nonzero pixels}
        tbl[0] = '{16, 12, 191, 25, 18, 191};
        tbl[1] = '{32, 24, 767, 17, 12, 765};
        tbl[2] = '{64, 48, 3071, 1, 0, 3060};
        tbl[3] = '{70, 50, 3071, 1, 0, 3060};
        tbl[4] = '{0, 12, 3071, -1, -1, 0};
        tbl[5] = '{15, 11, 164, 25, 18, 164};

        img_width = 10'(tbl[0].win); img_height = 10'(tbl[0].hin);
        repeat (3) @(posedge clk);
        #2;
        check("reset fb_addr", int'(fb_addr), 0);
        check("reset hsync", int'(vga_hsync), 1);
        check("reset vsync", int'(vga_vsync), 1);
        check("reset blank_n", int'(vga_blank_n), 0);
        check("reset rgb", int'({vga_r, vga_g, vga_b}), 0);
        check("reset frame_start", int'(frame_start), 0);
        reset = 1'b0;

        for (int i = 1; i < 6; i++) begin
            wait_k(i * FRAME - 100);
            img_width = 10'(tbl[i].win); img_height = 10'(tbl[i].hin);
            $display("vector %0d: apply %0dx%0d", i, tbl[i].win, tbl[i].hin);
        end
        // Geometry change in the middle of a frame only affects the next one.
        wait_k(6 * FRAME - 100);
        img_width = 10'd16; img_height = 10'd12;
        wait_k(6 * FRAME + 20 * H_TOT);
        img_width = 10'd32; img_height = 10'd24;
        $display("mid-frame change to 32x24 at line 20 of frame 6");
        wait_k(8 * FRAME - 100);
        img_width = 10'($urandom_range(0, 80)); img_height = 10'($urandom_range(0, 60));
        $display("random geometry %0dx%0d for frame 8", img_width, img_height);
        wait_k(8 * FRAME + 10);

        for (int i = 0; i < 6; i++)
            check_frame(i, tbl[i].last, tbl[i].first_col, tbl[i].first_line, tbl[i].nz);
        check_frame(6, 191, 25, 18, 191);
        check_frame(7, 767, 17, 12, 765);

        // Asynchronous reset in the middle of an image line.
        wait_k(9 * FRAME - 100);
        img_width = 10'd64; img_height = 10'd48;
        wait_k(9 * FRAME + 30 * H_TOT + 40);
        #5;
        reset = 1'b1;
        #1;
        check("async fb_addr", int'(fb_addr), 0);
        check("async hsync", int'(vga_hsync), 1);
        check("async vsync", int'(vga_vsync), 1);
        check("async blank_n", int'(vga_blank_n), 0);
        check("async rgb", int'({vga_r, vga_g, vga_b}), 0);
        check("async frame_start", int'(frame_start), 0);
        $display("mid-line reset applied");
        repeat (3) @(posedge clk);
        #2;
        img_width = 10'd32; img_height = 10'd24;
        reset = 1'b0;
        found = 0; pos = -1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (frame_start) begin found = 1; pos = i; end
        end
        check("frame_start delay", pos, LAT);
        wait_k(FRAME + 20);
        check("post-reset last_addr", st_last_addr[0], 767);
        check("post-reset first_col", st_first_col[0], 17);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
